// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming N-to-2^N decoder.
package decoder_pkg;

  // Buffer occupancy of the two-entry stream buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  // Widest code the helper handles; the top level slices the result.
  localparam int MAX_CODE_W = 6;
  localparam int MAX_OUT_W  = 1 << MAX_CODE_W;

  // Default geometry: 2-bit code, 4-bit one-hot word.
  localparam int DEF_N     = 2;
  localparam int DEF_OUT_W = 1 << DEF_N;

  // One-hot of code when en is set, all-zero otherwise.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic en,
                                                  input logic [MAX_CODE_W-1:0] code);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if (en) r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry stream buffer with registered in_ready/out_valid.
// Head entry is always head_q; the second entry waits in tail_q.
module decoder_fifo2
  import decoder_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         state_q, state_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         push, pop;

  // Next occupancy and entry movement from the two handshakes.
  always_comb begin
    push        = in_valid & in_ready_q;
    pop         = out_valid_q & out_ready;
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Registered state; in_ready stays low on the reset edge so it rises
  // only once rst_n has been sampled high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Handshake outputs are also held off for the whole time reset is low.
  assign in_ready  = in_ready_q & rst_n;
  assign out_valid = out_valid_q & rst_n;
  assign out_data  = head_q;

endmodule

// File: rtl/decoder_24_stream.sv
// Flow-controlled N-to-2^N decoder: buffers {en, code} and decodes the head.
// Optional per-line saturating hit counters: define DECODER_HIT_CNT_EN.
module decoder_24_stream
  import decoder_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      i,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [(1<<N)-1:0] y,
  output logic              out_valid,
  input  logic              out_ready
`ifdef DECODER_HIT_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [(1<<N)*CNT_W-1:0]   hit_cnt
`endif
);

  localparam int OUT_W = 1 << N;

  logic [N:0]              head;
  logic [MAX_CODE_W-1:0]   code_ext;
  logic [MAX_OUT_W-1:0]    oh;

  decoder_fifo2 #(.W(N + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({en, i}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (head),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Decode the head entry; an idle output reads as zero.
  always_comb begin
    code_ext         = '0;
    code_ext[N-1:0]  = head[N-1:0];
    oh               = onehot(head[N], code_ext);
    y                = out_valid ? oh[OUT_W-1:0] : '0;
  end

`ifdef DECODER_HIT_CNT_EN
  logic [OUT_W-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        pop;

  // Count popped hits per line, saturating; clear overrides a same-cycle pop.
  always_comb begin
    pop   = out_valid & out_ready;
    cnt_d = cnt_q;
    for (int j = 0; j < OUT_W; j++) begin
      if (cnt_clr)
        cnt_d[j] = '0;
      else if (pop && y[j] && (cnt_q[j] != {CNT_W{1'b1}}))
        cnt_d[j] = cnt_q[j] + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign hit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_decoder_24_stream.sv
// Directed + scoreboarded bench for decoder_24_stream (N=2).
// Counter checks are active when DECODER_HIT_CNT_EN is defined.
module tb_decoder_24_stream;

  localparam int N     = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     i;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] y;
  logic             out_valid;
  logic             out_ready;
`ifdef DECODER_HIT_CNT_EN
  logic                     cnt_clr;
  logic [OUT_W*CNT_W-1:0]   hit_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_24_stream #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DECODER_HIT_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .hit_cnt   (hit_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_y(input logic e, input logic [1:0] c);
    logic [3:0] r;
    r = 4'b0000;
    if (e) r[c] = 1'b1;
    return r;
  endfunction

  logic [2:0] sb[$];
  logic [2:0] ent;
  int         guard;
  logic [3:0] cnt_before;

  initial begin
    rst_n = 1'b0; i = '0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef DECODER_HIT_CNT_EN
    cnt_clr = 1'b0;
`endif
    #1;
    step(); step();
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef DECODER_HIT_CNT_EN
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    chk("in_ready_before_sample", 32'(in_ready), 32'd0);
    step();
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back decode of all codes, one cycle latency
    en = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i = 2'(c);
      step();
      chk($sformatf("seq_vld_%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("seq_y_%0d", c), 32'(y), 32'(4'b0001 << c));
      chk($sformatf("seq_rdy_%0d", c), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("seq_drain", 32'(out_valid), 32'd0);

    // en=0 gives a valid all-zero word that counts nowhere
`ifdef DECODER_HIT_CNT_EN
    cnt_before = hit_cnt[2*CNT_W +: CNT_W];
`else
    cnt_before = 4'd0;
`endif
    i = 2'd2; en = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("en0_vld", 32'(out_valid), 32'd1);
    chk("en0_y", 32'(y), 32'd0);
    step();
    chk("en0_drain", 32'(out_valid), 32'd0);
`ifdef DECODER_HIT_CNT_EN
    chk("en0_cnt", 32'(hit_cnt[2*CNT_W +: CNT_W]), 32'(cnt_before));
`endif

    // Backpressure fills both entries
    out_ready = 1'b0; en = 1'b1; in_valid = 1'b1; i = 2'd1;
    step();
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    chk("bp_y1", 32'(y), 32'h2);
    i = 2'd3;
    step();
    in_valid = 1'b0;
    chk("bp_rdy2", 32'(in_ready), 32'd0);
    chk("bp_y2", 32'(y), 32'h2);
    step();
    chk("bp_hold_y", 32'(y), 32'h2);
    chk("bp_hold_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_rel_y", 32'(y), 32'h8);
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_rel_empty", 32'(out_valid), 32'd0);

    // Random handshakes against a FIFO scoreboard
    sb.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      i         = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious", 32'(out_valid), 32'd0);
        end else begin
          ent = sb.pop_front();
          chk("rnd_y", 32'(y), 32'(exp_y(ent[2], ent[1:0])));
        end
      end
      if (in_valid && in_ready) sb.push_back({en, i});
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (out_valid && guard < 10) begin
      if (sb.size() == 0) begin
        chk("rnd_drain_spurious", 32'(out_valid), 32'd0);
      end else begin
        ent = sb.pop_front();
        chk("rnd_drain_y", 32'(y), 32'(exp_y(ent[2], ent[1:0])));
      end
      step();
      guard++;
    end
    chk("rnd_leftover", 32'(sb.size()), 32'd0);
    chk("rnd_drain_bound", 32'(out_valid), 32'd0);

`ifdef DECODER_HIT_CNT_EN
    // Saturation and clear-vs-pop priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt", 32'(hit_cnt[3*CNT_W +: CNT_W]), 32'd0);
    i = 2'd3; en = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) step();
    in_valid = 1'b0;
    step();
    chk("sat_cnt", 32'(hit_cnt[3*CNT_W +: CNT_W]), 32'd15);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_pop_cnt", 32'(hit_cnt[3*CNT_W +: CNT_W]), 32'd0);
    chk("clr_pop_empty", 32'(out_valid), 32'd0);
`endif

    // Reset with the buffer full discards everything
    out_ready = 1'b0; en = 1'b1; in_valid = 1'b1; i = 2'd0;
    step();
    i = 2'd1;
    step();
    in_valid = 1'b0;
    chk("full_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    chk("rstfull_vld", 32'(out_valid), 32'd0);
    chk("rstfull_y", 32'(y), 32'd0);
    chk("rstfull_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rstfull_rdy_back", 32'(in_ready), 32'd1);
    chk("rstfull_discard", 32'(out_valid), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; i = 2'd2; en = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_y", 32'(y), 32'h4);
    chk("post_rst_vld", 32'(out_valid), 32'd1);
    step();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_24_stream.md
# decoder_24_stream

Registered, flow-controlled N-to-2^N binary decoder: the receiving-side counterpart of the team's 4:2 encoder. It accepts binary codes on a valid/ready input and drives one-hot words on a valid/ready output through a two-entry buffer, so it sustains one code per cycle under backpressure. With N=2 it turns the encoder's `y` code back into its one-hot `i` word. Optional per-line saturating hit counters support link-level debug.

## Interface
Parameters:
- `N`, 2, code width; output width is 2^N.
- `CNT_W`, 8, width of each hit counter (used only with counters compiled in).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `i`  in  N  binary code.
- `en`  in  1  decode enable, captured with `i`; 0 means emit an all-zero word.
- `in_valid`  in  1  `i`/`en` valid.
- `in_ready`  out  1  block can accept this cycle.
- `y`  out  2^N  one-hot (or zero) output word.
- `out_valid`  out  1  `y` valid.
- `out_ready`  in  1  downstream accepts `y`.
- `cnt_clr`  in  1  synchronous clear of all hit counters (counter build only).
- `hit_cnt`  out  2^N*CNT_W  packed counters; line j at bits [j*CNT_W +: CNT_W] (counter build only).

## Operation
- Input handshake: a push occurs when `in_valid && in_ready`. Output handshake: a pop occurs when `out_valid && out_ready`.
- Each entry stores `{en, i}`. The head entry drives `y`: `y = en ? (1 << i) : 0`. When `out_valid` is 0, `y` is 0.
- Occupancy states:
  - EMPTY: `in_ready`=1, `out_valid`=0. A push moves the state to ONE.
  - ONE: `in_ready`=1, `out_valid`=1.
    - Push with pop stays in ONE; the new entry becomes the head.
    - Push only moves to FULL.
    - Pop only moves to EMPTY.
  - FULL: `in_ready`=0, `out_valid`=1. A pop moves the state to ONE. A push cannot occur.
- `in_ready` depends only on registered state. It has no combinational path from `out_ready`.
- Entries leave in arrival order. No entry is dropped or duplicated.
- While `out_valid`=1 and `out_ready`=0, `y` holds stable.
- Hit counters:
  - On a pop, `hit_cnt[j]` increments when `y[j]`=1.
  - A word with `en`=0 counts nowhere.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - If `cnt_clr` and a pop occur in the same cycle, the clear wins and the counter reads 0.

## Timing
- Latency: a code pushed at edge k appears on `y` with `out_valid`=1 from edge k+1, provided the buffer was empty.
- Throughput: one word per cycle while `out_ready`=1.
- With `out_ready`=0, two pushes fill the buffer. `in_ready` falls in the cycle after the second push.
- Reset (while `rst_n`=0, and after the reset edge):
  - State goes to EMPTY; `out_valid`=0, `y`=0, all `hit_cnt`=0.
  - `in_ready` is forced 0 while `rst_n`=0.
  - `in_ready` returns to 1 in the first cycle after `rst_n` is sampled high.
- Reset mid-transfer discards all buffered entries. No partial output follows.
- Out-of-range codes cannot occur, since `i` is exactly N bits.

## Configuration
- `DECODER_HIT_CNT_EN` defined: counters, `cnt_clr` and `hit_cnt` are present.
- Not defined: counter logic, `cnt_clr` and `hit_cnt` are removed from the port list. Decode and handshake behaviour is unchanged.

## Structure
- Shared package `decoder_pkg` holds:
  - the occupancy state enum (EMPTY/ONE/FULL);
  - function `onehot(en, code)`;
  - localparam `OUT_W = 1 << N` pattern.
- One sub-module, `decoder_fifo2`: a two-entry, registered-ready buffer parameterised on data width. It is instantiated with width N+1.
- The top level adds the decode on the head entry and the counters.

## Test plan
- Reset, then push `i`=0,1,2,3 with `en`=1 and `out_ready`=1 → `y` = 0001, 0010, 0100, 1000 on consecutive cycles, each one cycle after its push.
- Push `i`=2 with `en`=0 → `y`=0000 with `out_valid`=1; the counter build shows no counter change.
- Hold `out_ready`=0 and push `i`=1 then `i`=3 → `in_ready`=0 after the second push and `y`=0010 holds. Release `out_ready` → 0010 then 1000 emerge; `in_ready` returns to 1.
- Random `in_valid`/`out_ready` for 1000 cycles → output sequence equals input sequence, with no loss or duplication.
- Counter build, `CNT_W`=4, 20 pops of `i`=3 → `hit_cnt[3]`=15 (saturated). Assert `cnt_clr` coincident with a pop → `hit_cnt[3]`=0.
- Assert `rst_n`=0 with the buffer FULL → `out_valid`=0, `y`=0 and `in_ready`=0 next cycle. After release, the first push is decoded normally.
